control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired control unit for the single-core processor datapath. Steps a T-state machine through instruction fetch (T0–T2) and per-opcode execute steps (T3–T7). In each step it drives the datapath's one-hot register-transfer, ALU-select and memory strobes, replacing hand-driven control signals in `proc`. It sits beside the datapath, reads the latched IR and CON flip-flop, and owns run/halt state.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; forces state RST
- `ir`  in  32  instruction register contents; opcode = `ir[31:27]`
- `con_ff`  in  1  branch-condition flip-flop output from the CON FF logic
- `stop`  in  1  level; finish current instruction, then halt
- `PCout`, `PCin`, `IncPC`  out  1 each  PC bus drive / load / increment
- `MARin`, `MDRin`, `MDRout`, `Read`, `Write`  out  1 each  memory interface strobes
- `IRin`  out  1  IR load
- `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, `BAout`  out  1 each  register-file select and strobes
- `Yin`, `Zin`, `Zlowout`, `Cout`  out  1 each  ALU operand/result and immediate drive
- `ADD`, `SUB`, `AND`, `OR`  out  1 each  ALU op select; at most one high
- `CONin`  out  1  CON FF load
- `run`  out  1  high while executing; low in RST and HALT
- `clear`  out  1  high only in RST
- `step`  out  4  debug state code: RST=15, T0..T7=0..7, HALT=14

## Operation
- Outputs are combinational from state, `ir[31:27]` and `con_ff`. Any signal not listed for a step is 0.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin
  - T1: Zlowout, PCin, Read, MDRin
  - T2: MDRout, IRin
- IR is valid from T3 onward. The opcode is decoded only in T3–T7.
- Execute steps by opcode. After the last listed step, go to T0, or to HALT if `stop` is 1 or the opcode is halt.
- ld 00000:
  - T3: Grb, BAout, Yin
  - T4: Cout, ADD, Zin
  - T5: Zlowout, MARin
  - T6: Read, MDRin
  - T7: MDRout, Gra, Rin
- ldi 00001:
  - T3: Grb, BAout, Yin
  - T4: Cout, ADD, Zin
  - T5: Zlowout, Gra, Rin
- st 00010:
  - T3: Grb, BAout, Yin
  - T4: Cout, ADD, Zin
  - T5: Zlowout, MARin
  - T6: Gra, Rout, MDRin
  - T7: Write
- add/sub/and/or 00011/00100/00101/00110:
  - T3: Grb, Rout, Yin
  - T4: Grc, Rout, op select, Zin
  - T5: Zlowout, Gra, Rin
- addi 01100:
  - T3: Grb, Rout, Yin
  - T4: Cout, ADD, Zin
  - T5: Zlowout, Gra, Rin
- br 10010:
  - T3: Gra, Rout, CONin
  - T4: PCout, Yin
  - T5: Cout, ADD, Zin
  - T6: Zlowout and PCin only if `con_ff`=1, otherwise no strobes
- jal 10011:
  - T3: PCout, Grb, Rin (link)
  - T4: Gra, Rout, PCin
- jr 10100:
  - T3: Gra, Rout, PCin
- nop 11010 and any undefined opcode: T3 has no strobes.
- halt 11011: T3 has no strobes, then HALT.
- HALT is absorbing: all strobes 0, `run`=0. Only `reset` exits HALT.
- `stop` is sampled in the last execute step only. Asserting it mid-instruction never truncates that instruction.

## Timing
- One T-step per clock. Instruction latency in cycles: ld 8, ldi 6, st 8, ALU 6, addi 6, br 7, jal 5, jr 4, nop 4, halt 4 (then HALT).
- Reset:
  - `reset`=1 at an edge puts the state in RST.
  - While in RST: `clear`=1, `run`=0, `step`=15, all strobes 0.
  - First edge with `reset`=0 goes to T0.
- Reset wins over every other event, including mid-instruction (e.g. st in T6: Write is never issued) and HALT.
- `con_ff` is sampled combinationally in br T6. It must be stable from T4, having been loaded at the end of T3.
- Read and Write are never high in the same cycle. No step drives more than one bus source (PCout, Zlowout, MDRout, Rout, BAout, Cout).

## Test plan
- **Reset then fetch.** Hold reset 2 cycles, release → `step` 15,15,0,1,2. In T0 `PCout`=`MARin`=`IncPC`=`Zin`=1. `clear`=1 only while in RST.
- **ldi R1,35 with PC=7 in proc.** After 6 cycles R1=35 and PC=8. Next `step` is 0.
- **add R3,R1,R2 with R1=5, R2=7.** T4 has `ADD`=1 and `Grc`=1. R3=12 after T5. The instruction took 6 cycles.
- **brzr taken/not-taken with R2=0 / R2=4, C2=±3 from PC=20.** PC=24 when taken, 21 when not. PCin is high in T6 only when taken.
- **jal R1 with link R2, R1=40, PC=10.** R2=11 after T3 and PC=40 after T4. A subsequent jr R2 returns PC to 11.
- **Halt, stop and mid-st reset.**
  - halt → `run`=0 and `step`=14 indefinitely.
  - `stop` pulsed during ld T4 → ld completes, then HALT.
  - reset during st T6 → Write never asserted, RST next cycle.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired T-state control unit driving the datapath strobes for fetch and per-opcode execute steps.
module control_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        stop,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        Write,
  output logic        IRin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Cout,
  output logic        ADD,
  output logic        SUB,
  output logic        AND,
  output logic        OR,
  output logic        CONin,
  output logic        run,
  output logic        clear,
  output logic [3:0]  step
);
  localparam logic [3:0] S_T0   = 4'd0;
  localparam logic [3:0] S_T7   = 4'd7;
  localparam logic [3:0] S_HALT = 4'd14;
  localparam logic [3:0] S_RST  = 4'd15;
  logic [3:0] state, nxt, last;
  logic [4:0] op;
  logic [7:0] t;
  logic is_ld, is_ldi, is_st, is_add, is_sub, is_and, is_or, is_addi, is_br, is_jal, is_jr, is_halt;
  logic mem, alu, ri;
  logic unused_ir;
  assign op        = ir[31:27];
  assign unused_ir = ^ir[26:0];
  assign is_ld   = op == 5'b00000;
  assign is_ldi  = op == 5'b00001;
  assign is_st   = op == 5'b00010;
  assign is_add  = op == 5'b00011;
  assign is_sub  = op == 5'b00100;
  assign is_and  = op == 5'b00101;
  assign is_or   = op == 5'b00110;
  assign is_addi = op == 5'b01100;
  assign is_br   = op == 5'b10010;
  assign is_jal  = op == 5'b10011;
  assign is_jr   = op == 5'b10100;
  assign is_halt = op == 5'b11011;
  assign mem = is_ld | is_ldi | is_st;
  assign alu = is_add | is_sub | is_and | is_or;
  assign ri  = alu | is_addi;
  assign t   = (state <= S_T7) ? 8'd1 << state[2:0] : 8'd0;
  always_comb begin
    last = (is_ld | is_st) ? 4'd7 : is_br ? 4'd6 : (is_ldi | ri) ? 4'd5 : is_jal ? 4'd4 : 4'd3;
    nxt  = state == S_HALT ? S_HALT :
           state > S_T7    ? S_T0 :
           state == last   ? ((stop | is_halt) ? S_HALT : S_T0) :
                             state + 4'd1;
  end
  always_ff @(posedge clk)
    state <= reset ? S_RST : nxt;
  assign PCout   = t[0] | (is_br & t[4]) | (is_jal & t[3]);
  assign PCin    = t[1] | (is_br & t[6] & con_ff) | (is_jal & t[4]) | (is_jr & t[3]);
  assign IncPC   = t[0];
  assign MARin   = t[0] | ((is_ld | is_st) & t[5]);
  assign MDRin   = t[1] | ((is_ld | is_st) & t[6]);
  assign MDRout  = t[2] | (is_ld & t[7]);
  assign Read    = t[1] | (is_ld & t[6]);
  assign Write   = is_st & t[7];
  assign IRin    = t[2];
  assign Gra     = (is_ld & t[7]) | ((is_ldi | ri) & t[5]) | (is_st & t[6]) |
                   ((is_br | is_jr) & t[3]) | (is_jal & t[4]);
  assign Grb     = (mem | ri | is_jal) & t[3];
  assign Grc     = alu & t[4];
  assign Rin     = (is_ld & t[7]) | ((is_ldi | ri) & t[5]) | (is_jal & t[3]);
  assign Rout    = (is_st & t[6]) | ((ri | is_br | is_jr) & t[3]) | (alu & t[4]) | (is_jal & t[4]);
  assign BAout   = mem & t[3];
  assign Yin     = ((mem | ri) & t[3]) | (is_br & t[4]);
  assign Zin     = t[0] | ((mem | ri) & t[4]) | (is_br & t[5]);
  assign Zlowout = t[1] | ((mem | ri) & t[5]) | (is_br & t[6] & con_ff);
  assign Cout    = ((mem | is_addi) & t[4]) | (is_br & t[5]);
  assign ADD     = ((mem | is_addi | is_add) & t[4]) | (is_br & t[5]);
  assign SUB     = is_sub & t[4];
  assign AND     = is_and & t[4];
  assign OR      = is_or & t[4];
  assign CONin   = is_br & t[3];
  assign run     = state != S_RST && state != S_HALT;
  assign clear   = state == S_RST;
  assign step    = state;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed stimulus with a per-cycle instruction-table model plus literal checks.
module tb_control_sequencer;
  logic clk = 1'b0;
  logic reset, con_ff, stop;
  logic [31:0] ir;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Gra, Grb, Grc, Rin, Rout, BAout;
  logic Yin, Zin, Zlowout, Cout, ADD, SUB, AND, OR, CONin, run, clear;
  logic [3:0] step;
  logic [23:0] act;
  int n_chk = 0, n_fail = 0;
  localparam logic [23:0] NONE = 24'd0;
  localparam logic [23:0] PCOUT = 24'd1 << 0,  PCIN = 24'd1 << 1,  INCPC = 24'd1 << 2,  MARIN = 24'd1 << 3;
  localparam logic [23:0] MDRIN = 24'd1 << 4,  MDROUT = 24'd1 << 5, READ = 24'd1 << 6,  WRITE = 24'd1 << 7;
  localparam logic [23:0] IRIN = 24'd1 << 8,   GRA = 24'd1 << 9,    GRB = 24'd1 << 10,  GRC = 24'd1 << 11;
  localparam logic [23:0] RIN = 24'd1 << 12,   ROUT = 24'd1 << 13,  BAOUT = 24'd1 << 14, YIN = 24'd1 << 15;
  localparam logic [23:0] ZIN = 24'd1 << 16,   ZLO = 24'd1 << 17,   COUT = 24'd1 << 18, ADDS = 24'd1 << 19;
  localparam logic [23:0] SUBS = 24'd1 << 20,  ANDS = 24'd1 << 21,  ORS = 24'd1 << 22,  CONIN = 24'd1 << 23;
  control_sequencer dut (
    .clk(clk), .reset(reset), .ir(ir), .con_ff(con_ff), .stop(stop),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
    .Read(Read), .Write(Write), .IRin(IRin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
    .Rout(Rout), .BAout(BAout), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Cout(Cout),
    .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .CONin(CONin), .run(run), .clear(clear), .step(step)
  );
  assign act = {CONin, OR, AND, SUB, ADD, Cout, Zlowout, Zin, Yin, BAout, Rout, Rin, Grc, Grb, Gra,
                IRin, Write, Read, MDRout, MDRin, MARin, IncPC, PCin, PCout};
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
    end
  endtask
  // Instruction length in cycles, fetch included.
  function automatic int ilen(input logic [4:0] op);
    case (op)
      5'd0, 5'd2: return 8;
      5'd1, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12: return 6;
      5'd18: return 7;
      5'd19: return 5;
      default: return 4;
    endcase
  endfunction
  function automatic logic [23:0] emask(input logic [4:0] op, input int k, input logic c);
    logic [23:0] s [5];
    logic [23:0] aop;
    if (k == 0) return PCOUT | MARIN | INCPC | ZIN;
    if (k == 1) return ZLO | PCIN | READ | MDRIN;
    if (k == 2) return MDROUT | IRIN;
    aop = op == 5'd3 ? ADDS : op == 5'd4 ? SUBS : op == 5'd5 ? ANDS : ORS;
    case (op)
      5'd0:  s = '{GRB | BAOUT | YIN, COUT | ADDS | ZIN, ZLO | MARIN, READ | MDRIN, MDROUT | GRA | RIN};
      5'd1:  s = '{GRB | BAOUT | YIN, COUT | ADDS | ZIN, ZLO | GRA | RIN, NONE, NONE};
      5'd2:  s = '{GRB | BAOUT | YIN, COUT | ADDS | ZIN, ZLO | MARIN, GRA | ROUT | MDRIN, WRITE};
      5'd3, 5'd4, 5'd5, 5'd6: s = '{GRB | ROUT | YIN, GRC | ROUT | aop | ZIN, ZLO | GRA | RIN, NONE, NONE};
      5'd12: s = '{GRB | ROUT | YIN, COUT | ADDS | ZIN, ZLO | GRA | RIN, NONE, NONE};
      5'd18: s = '{GRA | ROUT | CONIN, PCOUT | YIN, COUT | ADDS | ZIN, c ? (ZLO | PCIN) : NONE, NONE};
      5'd19: s = '{PCOUT | GRB | RIN, GRA | ROUT | PCIN, NONE, NONE, NONE};
      5'd20: s = '{GRA | ROUT | PCIN, NONE, NONE, NONE, NONE};
      default: s = '{NONE, NONE, NONE, NONE, NONE};
    endcase
    return s[k - 3];
  endfunction
  bit valid = 0, m_rst = 0, m_halt = 0;
  int mk = 0;
  always @(posedge clk) begin
    if (reset) begin
      valid = 1; m_rst = 1; m_halt = 0; mk = 0;
    end else if (m_rst) begin
      m_rst = 0; mk = 0;
    end else if (!m_halt) begin
      if (mk >= 3 && mk == ilen(ir[31:27]) - 1) begin
        m_halt = stop || ir[31:27] == 5'd27;
        mk = 0;
      end else mk++;
    end
  end
  always @(negedge clk) if (valid) begin
    chk("model_step", 32'(step), m_rst ? 15 : m_halt ? 14 : mk);
    chk("model_strobes", 32'(act), (m_rst || m_halt) ? 32'd0 : 32'(emask(ir[31:27], mk, con_ff)));
    chk("model_run", 32'(run), 32'(!(m_rst || m_halt)));
    chk("model_clear", 32'(clear), 32'(m_rst));
    if (Read && Write) chk("read_write_excl", 32'(Read & Write), 0);
  end
  logic [23:0] hist [8];
  bit saw_write;
  int n;
  // Entered at the negedge of a T0 cycle; returns at the negedge where the next T0/HALT/RST shows.
  task automatic exec(input logic [4:0] op, input logic c, input int stop_k, input int rst_k);
    #1;
    ir = {op, 27'd0};
    con_ff = 1'b0;
    n = 0;
    saw_write = 0;
    for (int i = 0; i < 8; i++) hist[i] = NONE;
    repeat (20) begin
      if (step < 4'd8) hist[step[2:0]] = act;
      saw_write |= Write;
      n++;
      if (int'(step) == 3) con_ff = c;
      if (int'(step) == stop_k) stop = 1'b1;
      if (int'(step) == rst_k) reset = 1'b1;
      @(negedge clk);
      if (step == 4'd0 || step >= 4'd14) break;
      #1;
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b1; stop = 1'b0; con_ff = 1'b0; ir = 32'd0;
    @(negedge clk);
    chk("rst_step0", 32'(step), 15);
    chk("rst_clear", 32'(clear), 1);
    chk("rst_run", 32'(run), 0);
    @(negedge clk);
    chk("rst_step1", 32'(step), 15);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t0_step", 32'(step), 0);
    chk("t0_strobes", 32'(act), 32'(PCOUT | MARIN | INCPC | ZIN));
    chk("t0_clear", 32'(clear), 0);
    exec(5'd1, 1'b0, -1, -1);
    chk("ldi_len", n, 6);
    chk("ldi_t5", 32'(hist[5]), 32'(ZLO | GRA | RIN));
    chk("ldi_next", 32'(step), 0);
    exec(5'd3, 1'b0, -1, -1);
    chk("add_len", n, 6);
    chk("add_t4", 32'(hist[4]), 32'(GRC | ROUT | ADDS | ZIN));
    exec(5'd4, 1'b0, -1, -1);
    chk("sub_t4", 32'(hist[4]), 32'(GRC | ROUT | SUBS | ZIN));
    exec(5'd5, 1'b0, -1, -1);
    chk("and_t4", 32'(hist[4]), 32'(GRC | ROUT | ANDS | ZIN));
    exec(5'd6, 1'b0, -1, -1);
    chk("or_t4", 32'(hist[4]), 32'(GRC | ROUT | ORS | ZIN));
    exec(5'd18, 1'b1, -1, -1);
    chk("br_len", n, 7);
    chk("br_taken_t6", 32'(hist[6]), 32'(ZLO | PCIN));
    exec(5'd18, 1'b0, -1, -1);
    chk("br_not_taken_t6", 32'(hist[6]), 0);
    exec(5'd19, 1'b0, -1, -1);
    chk("jal_len", n, 5);
    chk("jal_t3", 32'(hist[3]), 32'(PCOUT | GRB | RIN));
    chk("jal_t4", 32'(hist[4]), 32'(GRA | ROUT | PCIN));
    exec(5'd20, 1'b0, -1, -1);
    chk("jr_len", n, 4);
    chk("jr_t3", 32'(hist[3]), 32'(GRA | ROUT | PCIN));
    exec(5'd0, 1'b0, -1, -1);
    chk("ld_len", n, 8);
    exec(5'd2, 1'b0, -1, -1);
    chk("st_len", n, 8);
    chk("st_t7", 32'(hist[7]), 32'(WRITE));
    exec(5'd12, 1'b0, -1, -1);
    chk("addi_len", n, 6);
    exec(5'd26, 1'b0, -1, -1);
    chk("nop_len", n, 4);
    chk("nop_t3", 32'(hist[3]), 0);
    exec(5'd31, 1'b0, -1, -1);
    chk("undef_len", n, 4);
    exec(5'd2, 1'b0, -1, 6);
    chk("st_rst_step", 32'(step), 15);
    chk("st_rst_nowrite", 32'(saw_write), 0);
    chk("st_rst_len", n, 7);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("st_rst_t0", 32'(step), 0);
    exec(5'd0, 1'b0, 4, -1);
    chk("ld_stop_len", n, 8);
    chk("ld_stop_t7", 32'(hist[7]), 32'(MDROUT | GRA | RIN));
    chk("ld_stop_halt", 32'(step), 14);
    repeat (3) begin
      @(negedge clk);
      chk("stop_halt_hold", 32'(step), 14);
    end
    #1 reset = 1'b1; stop = 1'b0;
    @(negedge clk);
    chk("halt_rst", 32'(step), 15);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("halt_rst_t0", 32'(step), 0);
    exec(5'd27, 1'b0, -1, -1);
    chk("halt_len", n, 4);
    chk("halt_step", 32'(step), 14);
    repeat (5) begin
      @(negedge clk);
      chk("halt_hold_step", 32'(step), 14);
      chk("halt_hold_run", 32'(run), 0);
      chk("halt_hold_strobes", 32'(act), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
